bin_to_one_hot_seq: RTL and testbench

Registered, parametrised successor of the team's binary-to-one-hot decoder. It holds a current index and drives it as either a one-hot or a thermometer vector. The index can be loaded from binary or stepped up/down with wrap or saturate. It sits in front of select/enable fabrics (mux selects, ring arbiters, channel enables) that need a glitch-free registered select vector plus its binary index.

---
 rtl/bin_to_one_hot_seq_pkg.sv | 15 +
 rtl/bin_to_one_hot_seq_decode.sv | 18 +
 rtl/bin_to_one_hot_seq.sv | 87 ++++++++
 tb/tb_bin_to_one_hot_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bin_to_one_hot_seq_pkg.sv
// Shared constants and state type for the registered binary-to-select-vector block.
package bin_onehot_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_one_hot_seq_decode.sv
// Combinational index decoder: one-hot or thermometer vector from a binary index.
module idx_vec_decode
    import bin_onehot_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             mode,
    output logic [N-1:0]     vec
);

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam logic [IDX_W-1:0] K = IDX_W'(k);
        assign vec[k] = (mode == MODE_THERM) ? (K <= idx) : (K == idx);
    end

endmodule

// File: rtl/bin_to_one_hot_seq.sv
// Registered index holder driving a glitch-free one-hot/thermometer select vector,
// loadable from binary and steppable up/down with wrap or saturate.
module bin_to_one_hot_seq
    import bin_onehot_pkg::*;
#(
    parameter int N         = 16,
    parameter int RESET_IDX = 0,
    parameter bit WRAP      = 1'b1,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             step_en,
    input  logic             step_dir,
    input  logic             mode,
    output logic [N-1:0]     out_vec,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    output logic             err_range,
    output logic             at_edge
);

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] RIDX  = IDX_W'(RESET_IDX);
    localparam logic [IDX_W-1:0] ZERO  = '0;
    localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

    state_t           state, next_state;
    logic [IDX_W-1:0] idx_q, next_idx;
    logic             next_err;
    logic [N-1:0]     dec_vec;

    always_comb begin
        next_state = state;
        next_idx   = idx_q;
        next_err   = 1'b0;
        if (clear) begin
            next_state = IDLE;
            next_idx   = RIDX;
        end else if (load_valid) begin
            if (32'(load_idx) < N) begin
                next_state = ACTIVE;
                next_idx   = load_idx;
            end else begin
                next_err = 1'b1;
            end
        end else if (step_en && state == ACTIVE) begin
            // Explicit compare against N-1 so non-power-of-two N never overflows into unused codes.
            if (step_dir == DIR_UP) begin
                if (idx_q == LAST) next_idx = WRAP ? ZERO : LAST;
                else               next_idx = idx_q + ONE;
            end else begin
                if (idx_q == ZERO) next_idx = WRAP ? LAST : ZERO;
                else               next_idx = idx_q - ONE;
            end
        end
    end

    idx_vec_decode #(.N(N), .IDX_W(IDX_W)) u_decode (
        .idx  (next_idx),
        .mode (mode),
        .vec  (dec_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx_q     <= RIDX;
            out_vec   <= '0;
            err_range <= 1'b0;
        end else begin
            state     <= next_state;
            idx_q     <= next_idx;
            out_vec   <= dec_vec & {N{next_state == ACTIVE}};
            err_range <= next_err;
        end
    end

    assign out_idx   = idx_q;
    assign out_valid = (state == ACTIVE);
    assign at_edge   = (state == ACTIVE) &&
                       ((step_dir == DIR_DN) ? (idx_q == ZERO) : (idx_q == LAST));

endmodule

// File: tb/tb_bin_to_one_hot_seq.sv
// Directed scoreboard bench over three configurations: N=16 wrap, N=16 saturate, N=10 wrap.
module tb_bin_to_one_hot_seq;

    typedef struct {
        string      name;
        logic       valid;
        logic [3:0] idx;
        logic [15:0] vec;
        logic       err;
        logic       edg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // DUT A: N=16, WRAP=1, RESET_IDX=2
    logic a_rst = 1'b1, a_clear = 1'b0, a_lv = 1'b0, a_se = 1'b0, a_sd = 1'b0, a_md = 1'b0;
    logic [3:0]  a_li = '0;
    logic [15:0] a_vec;
    logic [3:0]  a_idx;
    logic        a_valid, a_err, a_edge;

    // DUT B: N=16, WRAP=0, RESET_IDX=0
    logic b_rst = 1'b1, b_clear = 1'b0, b_lv = 1'b0, b_se = 1'b0, b_sd = 1'b0, b_md = 1'b0;
    logic [3:0]  b_li = '0;
    logic [15:0] b_vec;
    logic [3:0]  b_idx;
    logic        b_valid, b_err, b_edge;

    // DUT C: N=10, WRAP=1, RESET_IDX=0
    logic c_rst = 1'b1, c_clear = 1'b0, c_lv = 1'b0, c_se = 1'b0, c_sd = 1'b0, c_md = 1'b0;
    logic [3:0]  c_li = '0;
    logic [9:0]  c_vec;
    logic [3:0]  c_idx;
    logic        c_valid, c_err, c_edge;

    bin_to_one_hot_seq #(.N(16), .RESET_IDX(2), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .clear(a_clear), .load_valid(a_lv), .load_idx(a_li),
        .step_en(a_se), .step_dir(a_sd), .mode(a_md),
        .out_vec(a_vec), .out_idx(a_idx), .out_valid(a_valid), .err_range(a_err), .at_edge(a_edge));

    bin_to_one_hot_seq #(.N(16), .RESET_IDX(0), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .clear(b_clear), .load_valid(b_lv), .load_idx(b_li),
        .step_en(b_se), .step_dir(b_sd), .mode(b_md),
        .out_vec(b_vec), .out_idx(b_idx), .out_valid(b_valid), .err_range(b_err), .at_edge(b_edge));

    bin_to_one_hot_seq #(.N(10), .RESET_IDX(0), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst(c_rst), .clear(c_clear), .load_valid(c_lv), .load_idx(c_li),
        .step_en(c_se), .step_dir(c_sd), .mode(c_md),
        .out_vec(c_vec), .out_idx(c_idx), .out_valid(c_valid), .err_range(c_err), .at_edge(c_edge));

    task automatic check(input exp_t e, input logic v, input logic [3:0] i,
                         input logic [15:0] vec, input logic er, input logic eg);
        total++;
        if (v === e.valid && i === e.idx && vec === e.vec && er === e.err && eg === e.edg) begin
            passed++;
        end else begin
            $display("FAIL %s: got valid=%b idx=%0d vec=%h err=%b edge=%b, want valid=%b idx=%0d vec=%h err=%b edge=%b",
                     e.name, v, i, vec, er, eg, e.valid, e.idx, e.vec, e.err, e.edg);
        end
    endtask

    // Monitors: outputs settle after the edge; one expectation is consumed per driven cycle.
    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) check(qa.pop_front(), a_valid, a_idx, a_vec, a_err, a_edge);
        if (qb.size() > 0) check(qb.pop_front(), b_valid, b_idx, b_vec, b_err, b_edge);
        if (qc.size() > 0) check(qc.pop_front(), c_valid, c_idx, {6'b0, c_vec}, c_err, c_edge);
    end

    task automatic drive(input int d, input string nm,
                         input logic r, input logic cl, input logic lv, input logic [3:0] li,
                         input logic se, input logic sd, input logic md,
                         input logic ev, input logic [3:0] ei, input logic [15:0] evec,
                         input logic ee, input logic eg);
        exp_t e;
        @(negedge clk);
        {a_rst, a_clear, a_lv, a_se} = '0;
        {b_rst, b_clear, b_lv, b_se} = '0;
        {c_rst, c_clear, c_lv, c_se} = '0;
        e.name = nm; e.valid = ev; e.idx = ei; e.vec = evec; e.err = ee; e.edg = eg;
        case (d)
            0: begin
                a_rst = r; a_clear = cl; a_lv = lv; a_li = li; a_se = se; a_sd = sd; a_md = md;
                qa.push_back(e);
            end
            1: begin
                b_rst = r; b_clear = cl; b_lv = lv; b_li = li; b_se = se; b_sd = sd; b_md = md;
                qb.push_back(e);
            end
            default: begin
                c_rst = r; c_clear = cl; c_lv = lv; c_li = li; c_se = se; c_sd = sd; c_md = md;
                qc.push_back(e);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        //        dut name            rst clr lv li  se sd md   valid idx  vec        err edge
        drive(0, "a_reset",          1, 0, 0, 0,  0, 0, 0,   0, 2,  16'h0000, 0, 0);
        drive(0, "a_load5_onehot",   0, 0, 1, 5,  0, 0, 0,   1, 5,  16'h0020, 0, 0);
        drive(0, "a_mode_therm",     0, 0, 0, 0,  0, 0, 1,   1, 5,  16'h003F, 0, 0);
        drive(0, "a_load15",         0, 0, 1, 15, 0, 0, 0,   1, 15, 16'h8000, 0, 1);
        drive(0, "a_wrap_up",        0, 0, 0, 0,  1, 0, 0,   1, 0,  16'h0001, 0, 0);
        drive(0, "a_wrap_down",      0, 0, 0, 0,  1, 1, 0,   1, 15, 16'h8000, 0, 0);
        drive(0, "a_edge_at_15",     0, 0, 0, 0,  0, 0, 0,   1, 15, 16'h8000, 0, 1);
        drive(0, "a_clear_prio",     0, 1, 1, 7,  1, 0, 0,   0, 2,  16'h0000, 0, 0);
        drive(0, "a_step_idle",      0, 0, 0, 0,  1, 0, 0,   0, 2,  16'h0000, 0, 0);
        drive(0, "a_load_over_step", 0, 0, 1, 7,  1, 0, 0,   1, 7,  16'h0080, 0, 0);
        drive(0, "a_load11",         0, 0, 1, 11, 0, 0, 0,   1, 11, 16'h0800, 0, 0);
        drive(0, "a_rst_midrun",     1, 0, 1, 4,  0, 0, 0,   0, 2,  16'h0000, 0, 0);
        drive(0, "a_load0_dn_edge",  0, 0, 1, 0,  0, 1, 0,   1, 0,  16'h0001, 0, 1);
        drive(0, "a_therm_wrap_dn",  0, 0, 0, 0,  1, 1, 1,   1, 15, 16'hFFFF, 0, 0);

        drive(1, "b_reset",          1, 0, 0, 0,  0, 0, 0,   0, 0,  16'h0000, 0, 0);
        drive(1, "b_load0",          0, 0, 1, 0,  0, 1, 0,   1, 0,  16'h0001, 0, 1);
        drive(1, "b_sat_dn1",        0, 0, 0, 0,  1, 1, 0,   1, 0,  16'h0001, 0, 1);
        drive(1, "b_sat_dn2",        0, 0, 0, 0,  1, 1, 0,   1, 0,  16'h0001, 0, 1);
        drive(1, "b_sat_dn3",        0, 0, 0, 0,  1, 1, 0,   1, 0,  16'h0001, 0, 1);
        drive(1, "b_load15",         0, 0, 1, 15, 0, 0, 0,   1, 15, 16'h8000, 0, 1);
        drive(1, "b_sat_up",         0, 0, 0, 0,  1, 0, 0,   1, 15, 16'h8000, 0, 1);
        drive(1, "b_step_dn",        0, 0, 0, 0,  1, 1, 0,   1, 14, 16'h4000, 0, 0);
        drive(1, "b_therm14",        0, 0, 0, 0,  0, 0, 1,   1, 14, 16'h7FFF, 0, 0);

        drive(2, "c_reset",          1, 0, 0, 0,  0, 0, 0,   0, 0,  16'h0000, 0, 0);
        drive(2, "c_load3",          0, 0, 1, 3,  0, 0, 0,   1, 3,  16'h0008, 0, 0);
        drive(2, "c_load12_reject",  0, 0, 1, 12, 1, 0, 0,   1, 3,  16'h0008, 1, 0);
        drive(2, "c_err_one_cycle",  0, 0, 0, 0,  0, 0, 0,   1, 3,  16'h0008, 0, 0);
        drive(2, "c_load9",          0, 0, 1, 9,  0, 0, 0,   1, 9,  16'h0200, 0, 1);
        drive(2, "c_wrap_up_n10",    0, 0, 0, 0,  1, 0, 0,   1, 0,  16'h0001, 0, 0);
        drive(2, "c_wrap_dn_n10",    0, 0, 0, 0,  1, 1, 0,   1, 9,  16'h0200, 0, 0);
        drive(2, "c_therm9",         0, 0, 0, 0,  0, 1, 1,   1, 9,  16'h03FF, 0, 0);
        drive(2, "c_reset2",         1, 0, 0, 0,  0, 0, 0,   0, 0,  16'h0000, 0, 0);
        drive(2, "c_load15_idle",    0, 0, 1, 15, 0, 0, 0,   0, 0,  16'h0000, 1, 0);
        drive(2, "c_err_clears",     0, 0, 0, 0,  0, 0, 0,   0, 0,  16'h0000, 0, 0);

        repeat (3) @(negedge clk);
        total++;
        if (qa.size() + qb.size() + qc.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d expectations left, want 0",
                      qa.size() + qb.size() + qc.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
